// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO pad configuration serial loader.
package gpio_cfg_pkg;

  localparam int CFG_BITS_DEF = 13;

  // Bit positions inside one pad configuration word
  localparam int GPIO_MGMT_EN = 0;
  localparam int GPIO_OEB     = 1;
  localparam int GPIO_HLDH    = 2;
  localparam int GPIO_INP_DIS = 3;
  localparam int GPIO_MOD_SEL = 4;
  localparam int GPIO_AN_EN   = 5;
  localparam int GPIO_AN_SEL  = 6;
  localparam int GPIO_AN_POL  = 7;
  localparam int GPIO_SLOW    = 8;
  localparam int GPIO_TRIP    = 9;
  localparam int GPIO_DM_LSB  = 10;
  localparam int GPIO_DM_MSB  = 12;

  typedef enum logic [2:0] {
    IDLE, FETCH1, FETCH2, FETCH_W, SHIFT, LOAD, DONE
  } ld_state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gpio_serial_clkgen.sv
// Serial clock phase counter: low for CLK_DIV cycles, then high for CLK_DIV,
// restarting in the low phase whenever it is disabled.
module gpio_serial_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hi_q, hi_d;
  logic          last;

  assign last = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    if (!en_i) begin
      cnt_d = '0;
      hi_d  = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      hi_d  = ~hi_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      hi_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end

  // Strobes mark the last cycle of each phase
  assign rise_o = en_i & last & ~hi_q;
  assign fall_o = en_i & last & hi_q;

endmodule

// File: rtl/gpio_serial_loader.sv
// Streams per-pad config words from the config store into the two user-area
// GPIO shift chains, then pulses serial_load to latch them into the pads.
module gpio_serial_loader
  import gpio_cfg_pkg::*;
#(
  parameter int AREA1PADS  = 14,
  parameter int TOTAL_PADS = 27,
  parameter int CFG_BITS   = CFG_BITS_DEF,
  parameter int CLK_DIV    = 2
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          xfer_start,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_rd_en,
  output logic [$clog2(TOTAL_PADS)-1:0] cfg_rd_addr,
  input  logic [CFG_BITS-1:0]           cfg_rd_data,
  output logic                          serial_clock,
  output logic                          serial_load,
  output logic                          serial_resetn,
  output logic                          serial_data_1,
  output logic                          serial_data_2
);

  localparam int AW        = $clog2(TOTAL_PADS);
  localparam int AREA2PADS = TOTAL_PADS - AREA1PADS;
  localparam int STEPS     = imax(AREA1PADS, AREA2PADS);
  localparam int OFF1      = STEPS - AREA1PADS;
  localparam int OFF2      = STEPS - AREA2PADS;
  localparam int SW        = $clog2(STEPS + 1);
  localparam int BW        = $clog2(CFG_BITS + 1);

  ld_state_e           state_q;
  logic [SW-1:0]       step_q, step_n;
  logic [BW-1:0]       bit_q;
  logic [CFG_BITS-1:0] sh1_q, sh2_q;
  logic                busy_q, done_q, rd_en_q, sclk_q, load_q, resetn_q;
  logic [AW-1:0]       addr_q, addr1_n, addr2;
  logic                real1, real1_n, real2;
  logic                rise, fall;

  // Step about to be fetched when entering FETCH1
  assign step_n  = (state_q == IDLE) ? '0 : step_q + 1'b1;
  assign real1_n = int'(step_n) >= OFF1;
  assign addr1_n = AW'(AREA1PADS - 1 - (int'(step_n) - OFF1));
  assign real1   = int'(step_q) >= OFF1;
  assign real2   = int'(step_q) >= OFF2;
  assign addr2   = AW'(AREA1PADS + int'(step_q) - OFF2);

  gpio_serial_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .en_i  ((state_q == SHIFT) || (state_q == LOAD)),
    .rise_o(rise),
    .fall_o(fall)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      step_q   <= '0;
      bit_q    <= '0;
      sh1_q    <= '0;
      sh2_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      sclk_q   <= 1'b0;
      load_q   <= 1'b0;
      resetn_q <= 1'b0;
    end else begin
      resetn_q <= 1'b1;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      case (state_q)
        IDLE: if (xfer_start) begin
          busy_q  <= 1'b1;
          step_q  <= '0;
          state_q <= FETCH1;
          if (real1_n) begin
            rd_en_q <= 1'b1;
            addr_q  <= addr1_n;
          end
        end
        FETCH1: begin
          if (real2) begin
            rd_en_q <= 1'b1;
            addr_q  <= addr2;
          end
          state_q <= FETCH2;
        end
        FETCH2: begin
          sh1_q   <= real1 ? cfg_rd_data : '0;
          state_q <= FETCH_W;
        end
        FETCH_W: begin
          sh2_q   <= real2 ? cfg_rd_data : '0;
          bit_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (rise) sclk_q <= 1'b1;
          // Data only moves on the falling strobe, so it is stable while high
          if (fall) begin
            sclk_q <= 1'b0;
            sh1_q  <= sh1_q << 1;
            sh2_q  <= sh2_q << 1;
            if (bit_q == BW'(CFG_BITS - 1)) begin
              bit_q <= '0;
              if (step_q == SW'(STEPS - 1)) begin
                load_q  <= 1'b1;
                state_q <= LOAD;
              end else begin
                step_q  <= step_n;
                state_q <= FETCH1;
                if (real1_n) begin
                  rd_en_q <= 1'b1;
                  addr_q  <= addr1_n;
                end
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        LOAD: if (fall) begin
          load_q  <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_rd_en     = rd_en_q;
  assign cfg_rd_addr   = addr_q;
  assign serial_clock  = sclk_q;
  assign serial_load   = load_q;
  assign serial_resetn = resetn_q;
  assign serial_data_1 = sh1_q[CFG_BITS-1];
  assign serial_data_2 = sh2_q[CFG_BITS-1];

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Four loader instances (default, CLK_DIV=1, CLK_DIV=3, AREA1PADS=10) each with
// a config store model, chain models and a bit-level scoreboard.
module tb_gpio_serial_loader;

  localparam int NP = 27;
  localparam int CB = 13;

  logic            clk;
  logic            rst;
  logic [3:0]      start;
  logic [3:0][12:0] outs;
  int              nchk = 0;
  int              nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_i
    localparam int A1 = (g == 3) ? 10 : 14;
    localparam int CD = (g == 1) ? 1 : (g == 2) ? 3 : 2;
    localparam int A2 = NP - A1;
    localparam int ST = (A1 > A2) ? A1 : A2;

    logic          busy, done, rd_en, sclk, sload, sresetn, sd1, sd2;
    logic [4:0]    addr;
    logic [CB-1:0] rdata;

    gpio_serial_loader #(.AREA1PADS(A1), .TOTAL_PADS(NP), .CFG_BITS(CB), .CLK_DIV(CD)) u_dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .xfer_start   (start[g]),
      .busy         (busy),
      .done         (done),
      .cfg_rd_en    (rd_en),
      .cfg_rd_addr  (addr),
      .cfg_rd_data  (rdata),
      .serial_clock (sclk),
      .serial_load  (sload),
      .serial_resetn(sresetn),
      .serial_data_1(sd1),
      .serial_data_2(sd2)
    );

    assign outs[g] = {busy, done, rd_en, sclk, sload, sresetn, sd1, sd2, addr};

    // Config store: pad i holds 13'h1000|i; junk whenever no read is pending
    always @(posedge clk) rdata <= rd_en ? (13'h1000 | 13'(addr)) : 13'($urandom);

    int             nrise = 0, nrd = 0, run = 0, lrun = 0, nload = 0, ndone = 0;
    logic           psclk = 0, pload = 0, pbusy = 0, d1r = 0, d2r = 0, h1 = 0, h2 = 0;
    logic [NP*CB-1:0] ch1 = '0, ch2 = '0;
    logic [CB-1:0]  w1, w2;
    bit             q1[$], q2[$];

    always @(negedge clk) begin
      if (rst) begin
        q1.delete(); q2.delete();
        nrise = 0; nrd = 0; run = 0; lrun = 0;
        psclk = 0; pload = 0; pbusy = 0;
      end else begin
        if (start[g] && !busy) begin
          for (int s = 0; s < ST; s++) begin
            w1 = (s < ST - A1) ? '0 : CB'(13'h1000 | (ST - 1 - s));
            w2 = (s < ST - A2) ? '0 : CB'(13'h1000 | (NP - ST + s));
            for (int b = CB - 1; b >= 0; b--) begin
              q1.push_back(w1[b]);
              q2.push_back(w2[b]);
            end
          end
        end
        if (rd_en) nrd++;
        chk($sformatf("i%0d_sclk_idle", g), sclk & ~busy, 0);
        if (sclk != psclk) begin
          if (sclk) begin
            if (nrise % CB != 0) chk($sformatf("i%0d_lo_w", g), run, CD);
            ch1 = {ch1[NP*CB-2:0], sd1};
            ch2 = {ch2[NP*CB-2:0], sd2};
            if (q1.size() == 0 || q2.size() == 0) chk($sformatf("i%0d_q_underrun", g), 1, 0);
            else begin
              chk($sformatf("i%0d_bit1_%0d", g, nrise), sd1, q1.pop_front());
              chk($sformatf("i%0d_bit2_%0d", g, nrise), sd2, q2.pop_front());
            end
            d1r = sd1; d2r = sd2;
            nrise++;
          end else begin
            chk($sformatf("i%0d_hi_w", g), run, CD);
            chk($sformatf("i%0d_hold", g), {h1, h2}, {d1r, d2r});
          end
          run = 1;
        end else run++;
        if (sclk) begin h1 = sd1; h2 = sd2; end
        if (sload && !pload) begin
          chk($sformatf("i%0d_rises", g), nrise, ST * CB);
          chk($sformatf("i%0d_reads", g), nrd, NP);
          chk($sformatf("i%0d_q_left", g), q1.size() + q2.size(), 0);
          for (int p = 0; p < NP; p++)
            chk($sformatf("i%0d_pad%0d", g, p),
                (p < A1) ? ch1[CB*p +: CB] : ch2[CB*(NP-1-p) +: CB], 13'h1000 | p);
          nload++; nrise = 0; nrd = 0; lrun = 0;
        end
        if (sload) lrun++;
        if (!sload && pload) chk($sformatf("i%0d_ld_w", g), lrun, 2 * CD);
        if (done) begin
          ndone++;
          chk($sformatf("i%0d_done_busy", g), {busy, pbusy}, 2'b01);
          chk($sformatf("i%0d_done_ld", g), {sload, pload}, 2'b01);
        end
        psclk = sclk; pload = sload; pbusy = busy;
      end
    end
  end

  // Called at posedge+1; returns at the negedge after the start was accepted
  task automatic kick(input int g);
    start[g] = 1'b1;
    @(posedge clk); #1 start[g] = 1'b0;
    @(negedge clk);
    chk($sformatf("i%0d_busy_rise", g), outs[g][12], 1);
  endtask

  task automatic xfer(input int g, input bit rep);
    int cyc = 0;
    bit got = 0;
    kick(g);
    while (!got && cyc < 4000) begin
      @(posedge clk); #1 start[g] = rep && (cyc == 5 || cyc == 100);
      @(negedge clk);
      got = outs[g][11];
      cyc++;
    end
    start[g] = 1'b0;
    chk($sformatf("i%0d_done_seen", g), got, 1);
  endtask

  initial begin
    int nl, cyc;
    rst = 1'b0; start = '0;
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("i%0d_rst_val", k), outs[k], 0);
    @(posedge clk); #1 rst = 1'b0;
    #1 for (int k = 0; k < 4; k++) chk($sformatf("i%0d_resetn_rel", k), outs[k][7], 0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) chk($sformatf("i%0d_resetn_up", k), outs[k][7], 1);

    // Default config, with starts re-pulsed mid-transfer, then back-to-back start
    xfer(0, 1);
    @(posedge clk); #1;
    chk("i0_ndone_1", g_i[0].ndone, 1);
    xfer(0, 0);
    @(posedge clk); #1;
    chk("i0_ndone_2", g_i[0].ndone, 2);
    repeat (20) @(posedge clk);
    #1 chk("i0_idle_busy", outs[0][12], 0);
    chk("i0_ndone_after", g_i[0].ndone, 2);
    chk("i0_nload", g_i[0].nload, 2);

    // Other clock divisors and the asymmetric split
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      xfer(k, 0);
    end
    @(posedge clk); #1;
    chk("i1_nload", g_i[1].nload, 1);
    chk("i2_nload", g_i[2].nload, 1);
    chk("i3_nload", g_i[3].nload, 1);
    chk("i3_ndone", g_i[3].ndone, 1);

    // Reset in the middle of step 6
    kick(0);
    cyc = 0;
    while (g_i[0].nrise < 6 * CB + 5 && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    chk("i0_reach_step6", g_i[0].nrise >= 6 * CB + 5, 1);
    @(posedge clk); #1;
    nl = g_i[0].nload;
    rst = 1'b1;
    #1 chk("i0_rst_mid", outs[0], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("i0_resetn_rel2", outs[0][7], 0);
    @(posedge clk); #1;
    chk("i0_resetn_up2", outs[0][7], 1);
    chk("i0_no_load_rst", g_i[0].nload, nl);
    xfer(0, 0);
    @(posedge clk); #1;
    chk("i0_load_after_rst", g_i[0].nload, nl + 1);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
